seg7_readback: RTL and testbench
================================

SEG7_READBACK -- requirements
Module: seg7_readback

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset; reset asserts at any time and releases synchronously to clk_d.
REQ-002 clk_d  in  1  display scan clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 codificacion  in  7  sampled segment bus, active-low; bit6=a to bit0=g.
REQ-005 digito  in  4  sampled digit-enable bus, active-low one-cold; 4'b1110=pos0 (units), 4'b1101=pos1, 4'b1011=pos2, 4'b0111=pos3 (thousands).
REQ-006 valor  out  10  last decoded display value, binary.
REQ-007 valido  out  1  one-cycle pulse when valor is updated.
REQ-008 ovf  out  1  set with valido when the decoded value exceeds 1023; cleared with the next valido.
REQ-009 err_frame  out  1  one-cycle pulse on a scan-order violation.
REQ-010 err_seg  out  1  one-cycle pulse on an illegal segment pattern.

Function
REQ-011 Segment table (active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, blank=1111111; any other pattern is illegal.
REQ-012 Capture FSM states: WAIT, CAP1, CAP2, CAP3.
- WAIT: on digito=1110, capture pos0 and go to CAP1; otherwise stay in WAIT with no error.
- CAPn: digito equal to the expected position: capture and advance (CAP3 goes to WAIT).
- CAPn: digito equal to the previous position: hold and re-capture that position, no error.
- CAPn: any other digito: pulse err_frame, discard the frame, go to WAIT.
REQ-013 Abort same-cycle rule: if the aborting sample is digito=1110, it SHALL be captured as pos0 and the FSM SHALL go to CAP1.
REQ-014 Blank rules:
- Blank SHALL be legal only at pos1 to pos3, and only when every higher position is also blank (leading blank); it counts as digit 0.
- Blank at pos0, or a non-leading blank, SHALL be treated as illegal.
REQ-015 Illegal pattern: err_seg SHALL pulse on the edge following the offending sample; the frame is marked bad but capture continues to hold scan sync; a bad frame produces no valido.
REQ-016 On the edge that captures pos3 of a good frame, the four digits SHALL be snapshot into a separate accumulator register, so capture of the next frame proceeds without stall.
REQ-017 The accumulator SHALL be 14 bits wide and compute ((d3*10+d2)*10+d1)*10+d0 iteratively, one multiply-add per clk_d cycle.
REQ-018 valor and valido SHALL update on the 4th clk_d edge after the pos3 capture edge.
REQ-019 Results above 1023 SHALL saturate valor at 1023 and set ovf.
REQ-020 At back-to-back frames with the minimum 4-cycle period, every good frame SHALL produce exactly one valido.
REQ-021 err_frame and err_seg SHALL be able to pulse in the same cycle; valido SHALL never coincide with either error pulse of the same frame.

Reset
REQ-022 Asserting reset SHALL clear all outputs to 0: valor=0, valido=0, ovf=0, err_frame=0, err_seg=0.
REQ-023 Asserting reset SHALL force the FSM to WAIT and clear the digit registers, the snapshot, the accumulator, and any pending result.
REQ-024 Reset mid-frame or mid-accumulation SHALL discard that frame with no valido.

Configuration
REQ-025 Macro SEG7_RB_STABLE_EN defined: valido SHALL assert only when two consecutive good frames decode to the same value, on the second frame's result cycle.
REQ-026 With SEG7_RB_STABLE_EN defined:
- A differing value SHALL replace the comparison value and produce no valido.
- A bad frame SHALL clear the comparison history.
REQ-027 Macro SEG7_RB_STABLE_EN undefined: every good frame SHALL produce valido; no history logic SHALL be present.

Verification
REQ-028 Scan 1110/0000001, 1101/0000110, 1011/1111111, 0111/1111111 -> valor=30, valido pulse 4 edges after pos3, ovf=0.
REQ-029 Scan digits 0,0,0,1 (pos0 to pos3) -> valor=1000; repeated frames back-to-back -> one valido per frame, period 4 cycles.
REQ-030 Scan 9,9,9,9 -> valor=1023, ovf=1 with valido; next frame 0,5,blank,blank -> valor=50, ovf=0.
REQ-031 digito 1110 then 1011 -> err_frame pulse, no valido; a following clean frame of 75 -> valor=75.
REQ-032 pos1 pattern 1111110, or a blank at pos1 under a nonblank pos2 -> err_seg pulse, no valido, next good frame decodes normally.
REQ-033 With SEG7_RB_STABLE_EN defined, frames 125, 125, 150 -> single valido (valor=125) on the second frame; reset asserted during accumulation -> all outputs 0 and no valido.

Source files
------------

// File: rtl/seg7_readback.sv
// seg7_readback: recovers the binary value shown on a multiplexed 4-digit
// 7-segment display by sampling its active-low segment and digit buses.
// A capture FSM follows the scan (pos0..pos3), a snapshot decouples the
// finished frame from the next scan, and a 14-bit accumulator folds the
// digits with one multiply-add per clock.
// Optional feature: define SEG7_RB_STABLE_EN to report a value only when two
// consecutive good frames decode to the same result.
module seg7_readback (
    input  logic       clk_d,
    input  logic       reset,
    input  logic [6:0] codificacion,
    input  logic [3:0] digito,
    output logic [9:0] valor,
    output logic       valido,
    output logic       ovf,
    output logic       err_frame,
    output logic       err_seg
);

    // State encoding equals the digit position expected next.
    typedef enum logic [1:0] {WAIT, CAP1, CAP2, CAP3} state_t;

    // Returns {legal digit, blank, value}; an illegal pattern returns all zero.
    function automatic logic [5:0] seg_decode(input logic [6:0] pat);
        case (pat)
            7'b0000001: seg_decode = 6'b10_0000;
            7'b1001111: seg_decode = 6'b10_0001;
            7'b0010010: seg_decode = 6'b10_0010;
            7'b0000110: seg_decode = 6'b10_0011;
            7'b1001100: seg_decode = 6'b10_0100;
            7'b0100100: seg_decode = 6'b10_0101;
            7'b0100000: seg_decode = 6'b10_0110;
            7'b0001111: seg_decode = 6'b10_0111;
            7'b0000000: seg_decode = 6'b10_1000;
            7'b0000100: seg_decode = 6'b10_1001;
            7'b1111111: seg_decode = 6'b01_0000;
            default:    seg_decode = 6'b00_0000;
        endcase
    endfunction

    // Returns {one-cold code recognised, position index}.
    function automatic logic [2:0] pos_decode(input logic [3:0] dig);
        case (dig)
            4'b1110: pos_decode = 3'b100;
            4'b1101: pos_decode = 3'b101;
            4'b1011: pos_decode = 3'b110;
            4'b0111: pos_decode = 3'b111;
            default: pos_decode = 3'b000;
        endcase
    endfunction

    function automatic logic [13:0] mac10(input logic [13:0] acc, input logic [3:0] dig);
        mac10 = acc * 14'd10 + {10'd0, dig};
    endfunction

    function automatic logic [9:0] sat10(input logic [13:0] v);
        sat10 = (v > 14'd1023) ? 10'h3FF : v[9:0];
    endfunction

    state_t            state_q, state_d;
    logic [3:0][3:0]   dig_q, dig_d;
    logic [3:0]        blk_q, blk_d;
    logic              bad_q, bad_d;
    logic [3:0][3:0]   snap_q, snap_d;
    logic [13:0]       acc_q, acc_d;
    logic [2:0]        step_q, step_d;
    logic [9:0]        valor_q, valor_d;
    logic              valido_q, valido_d;
    logic              ovf_q, ovf_d;
    logic              err_frame_q, err_frame_d;
    logic              err_seg_q, err_seg_d;

    logic              pos_ok, dig_legal, dig_blank, capture, new_frame, seg_ok, lower_blank;
    logic [1:0]        pos_idx, exp_idx, prev_idx;
    logic [3:0]        dig_val, cap_val, lower_mask;
    logic              load;
    logic [3:0][3:0]   frame_digits;
    logic              res_vld, publish;
    logic [13:0]       res_val;

`ifdef SEG7_RB_STABLE_EN
    logic              hist_vld_q, hist_vld_d;
    logic [13:0]       hist_val_q, hist_val_d;
`endif

    // Scan-following capture FSM: position checks, segment legality, frame status.
    always_comb begin
        {pos_ok, pos_idx} = pos_decode(digito);
        {dig_legal, dig_blank, dig_val} = seg_decode(codificacion);
        exp_idx     = state_q;
        prev_idx    = exp_idx - 2'd1;
        state_d     = state_q;
        dig_d       = dig_q;
        blk_d       = blk_q;
        bad_d       = bad_q;
        capture     = 1'b0;
        err_frame_d = 1'b0;
        err_seg_d   = 1'b0;
        if (state_q == WAIT) begin
            if (pos_ok && pos_idx == 2'd0) begin
                capture = 1'b1;
                state_d = CAP1;
            end
        end else if (pos_ok && pos_idx == exp_idx) begin
            capture = 1'b1;
            state_d = state_t'(exp_idx + 2'd1);
        end else if (pos_ok && pos_idx == prev_idx) begin
            capture = 1'b1;
        end else begin
            // Scan violation; a pos0 sample restarts a frame in the same cycle.
            err_frame_d = 1'b1;
            if (pos_ok && pos_idx == 2'd0) begin
                capture = 1'b1;
                state_d = CAP1;
            end else begin
                state_d = WAIT;
            end
        end
        // A digit above any already-captured blank makes that blank non-leading.
        lower_mask  = (4'b0001 << pos_idx) - 4'b0001;
        lower_blank = |(blk_q & lower_mask);
        seg_ok      = dig_legal ? !lower_blank : (dig_blank && pos_idx != 2'd0);
        cap_val     = dig_legal ? dig_val : 4'd0;
        new_frame   = capture && pos_idx == 2'd0;
        if (capture) begin
            dig_d[pos_idx] = cap_val;
            if (new_frame) begin
                blk_d = {3'b000, dig_blank};
            end else begin
                blk_d[pos_idx] = dig_blank;
            end
            bad_d     = (new_frame ? 1'b0 : bad_q) | !seg_ok;
            err_seg_d = !seg_ok;
        end
        frame_digits    = dig_q;
        frame_digits[3] = cap_val;
        load = capture && pos_idx == 2'd3 && !bad_q && seg_ok;
    end

    // Snapshot and iterative accumulation: result ready on the 4th edge after load.
    always_comb begin
        acc_d   = acc_q;
        step_d  = step_q;
        snap_d  = snap_q;
        res_vld = 1'b0;
        res_val = 14'd0;
        case (step_q)
            3'd1: begin acc_d = mac10(14'd0, snap_q[3]); step_d = 3'd2; end
            3'd2: begin acc_d = mac10(acc_q, snap_q[2]); step_d = 3'd3; end
            3'd3: begin acc_d = mac10(acc_q, snap_q[1]); step_d = 3'd4; end
            3'd4: begin
                res_val = mac10(acc_q, snap_q[0]);
                res_vld = 1'b1;
                step_d  = 3'd0;
            end
            default: ;
        endcase
        if (load) begin
            snap_d = frame_digits;
            step_d = 3'd1;
        end
    end

    // Result publication, saturation and optional stability filter.
    always_comb begin
`ifdef SEG7_RB_STABLE_EN
        hist_vld_d = hist_vld_q;
        hist_val_d = hist_val_q;
        publish    = res_vld && hist_vld_q && (hist_val_q == res_val);
        if (res_vld) begin
            hist_vld_d = 1'b1;
            hist_val_d = res_val;
        end
        if (err_frame_d || err_seg_d) begin
            hist_vld_d = 1'b0;
        end
`else
        publish = res_vld;
`endif
        valido_d = publish;
        valor_d  = publish ? sat10(res_val) : valor_q;
        ovf_d    = publish ? (res_val > 14'd1023) : ovf_q;
    end

    // All state registers; reset discards any frame in flight.
    always_ff @(posedge clk_d or negedge reset) begin
        if (!reset) begin
            state_q     <= WAIT;
            dig_q       <= '0;
            blk_q       <= '0;
            bad_q       <= 1'b0;
            snap_q      <= '0;
            acc_q       <= '0;
            step_q      <= '0;
            valor_q     <= '0;
            valido_q    <= 1'b0;
            ovf_q       <= 1'b0;
            err_frame_q <= 1'b0;
            err_seg_q   <= 1'b0;
`ifdef SEG7_RB_STABLE_EN
            hist_vld_q  <= 1'b0;
            hist_val_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            dig_q       <= dig_d;
            blk_q       <= blk_d;
            bad_q       <= bad_d;
            snap_q      <= snap_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            valor_q     <= valor_d;
            valido_q    <= valido_d;
            ovf_q       <= ovf_d;
            err_frame_q <= err_frame_d;
            err_seg_q   <= err_seg_d;
`ifdef SEG7_RB_STABLE_EN
            hist_vld_q  <= hist_vld_d;
            hist_val_q  <= hist_val_d;
`endif
        end
    end

    assign valor     = valor_q;
    assign valido    = valido_q;
    assign ovf       = ovf_q;
    assign err_frame = err_frame_q;
    assign err_seg   = err_seg_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback: scans hand-built display frames and
// compares outputs against hand-computed values.
module tb_seg7_readback;

    localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010;
    localparam logic [6:0] S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100;
    localparam logic [6:0] S6 = 7'b0100000, S7 = 7'b0001111, S9 = 7'b0000100;
    localparam logic [6:0] SB = 7'b1111111, SX = 7'b1111110;
    localparam logic [3:0] P0 = 4'b1110, P1 = 4'b1101, P2 = 4'b1011, P3 = 4'b0111;
    localparam logic [3:0] PI = 4'b1111;

    logic       clk_d = 1'b0;
    logic       reset = 1'b1;
    logic [6:0] codificacion = SB;
    logic [3:0] digito = PI;
    logic [9:0] valor;
    logic       valido, ovf, err_frame, err_seg;

    int         checks = 0;
    int         errors = 0;
    int         vcnt = 0, efcnt = 0, escnt = 0;
    logic [15:0] vvec = '0;

    seg7_readback dut (
        .clk_d        (clk_d),
        .reset        (reset),
        .codificacion (codificacion),
        .digito       (digito),
        .valor        (valor),
        .valido       (valido),
        .ovf          (ovf),
        .err_frame    (err_frame),
        .err_seg      (err_seg)
    );

    always #5 clk_d = ~clk_d;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input logic [3:0] d, input logic [6:0] s);
        digito = d;
        codificacion = s;
        @(posedge clk_d);
        #1;
        if (valido) vcnt++;
        if (err_frame) efcnt++;
        if (err_seg) escnt++;
        vvec = {vvec[14:0], valido};
    endtask

    task automatic frame(input logic [6:0] a, input logic [6:0] b,
                         input logic [6:0] c, input logic [6:0] d);
        tick(P0, a);
        tick(P1, b);
        tick(P2, c);
        tick(P3, d);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(PI, SB);
    endtask

    task automatic clr();
        vcnt = 0;
        efcnt = 0;
        escnt = 0;
    endtask

    initial begin
        #2 reset = 1'b0;
        repeat (3) @(posedge clk_d);
        #1;
        chk("rst_valor", valor, 0);
        chk("rst_valido", valido, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_err_frame", err_frame, 0);
        chk("rst_err_seg", err_seg, 0);
        reset = 1'b1;

        // 0,3,blank,blank -> 30, four edges after the pos3 capture
        frame(S0, S3, SB, SB);
        idle(3);
        chk("v30_early", valido, 0);
        idle(1);
        chk("v30_valido", valido, 1);
        chk("v30_valor", valor, 30);
        chk("v30_ovf", ovf, 0);
        idle(1);
        chk("v30_pulse_end", valido, 0);

        // back-to-back 1000 frames
        clr();
        vvec = '0;
        frame(S0, S0, S0, S1);
        frame(S0, S0, S0, S1);
        frame(S0, S0, S0, S1);
        idle(4);
        chk("b2b_pattern", vvec, 16'h0111);
        chk("b2b_count", vcnt, 3);
        chk("b2b_valor", valor, 1000);
        chk("b2b_ovf", ovf, 0);

        // saturation then recovery
        frame(S9, S9, S9, S9);
        idle(4);
        chk("sat_valido", valido, 1);
        chk("sat_valor", valor, 1023);
        chk("sat_ovf", ovf, 1);
        frame(S0, S5, SB, SB);
        idle(3);
        chk("ovf_held", ovf, 1);
        idle(1);
        chk("v50_valido", valido, 1);
        chk("v50_valor", valor, 50);
        chk("v50_ovf", ovf, 0);

        // scan-order violation
        clr();
        tick(P0, S0);
        tick(P2, S0);
        chk("abort_err_frame", err_frame, 1);
        tick(PI, SB);
        chk("abort_err_end", err_frame, 0);
        idle(4);
        chk("abort_no_valido", vcnt, 0);
        frame(S5, S7, SB, SB);
        idle(4);
        chk("v75_valido", valido, 1);
        chk("v75_valor", valor, 75);

        // illegal pattern at pos1
        clr();
        tick(P0, S0);
        tick(P1, SX);
        chk("segx_err_seg", err_seg, 1);
        tick(P2, S0);
        chk("segx_err_end", err_seg, 0);
        tick(P3, S0);
        idle(4);
        chk("segx_no_valido", vcnt, 0);
        chk("segx_count", escnt, 1);

        // non-leading blank at pos1 under a digit at pos2
        clr();
        tick(P0, S0);
        tick(P1, SB);
        chk("nlb_pos1_ok", err_seg, 0);
        tick(P2, S2);
        chk("nlb_err_seg", err_seg, 1);
        tick(P3, SB);
        idle(4);
        chk("nlb_no_valido", vcnt, 0);
        frame(S1, S2, S3, SB);
        idle(4);
        chk("v321_valido", valido, 1);
        chk("v321_valor", valor, 321);

        // abort by pos0 restarts the frame in the same cycle
        clr();
        tick(P0, S1);
        tick(P1, S1);
        tick(P0, S6);
        chk("restart_err_frame", err_frame, 1);
        tick(P1, S4);
        tick(P2, SB);
        tick(P3, SB);
        idle(4);
        chk("restart_valor", valor, 46);
        chk("restart_vcnt", vcnt, 1);
        chk("restart_efcnt", efcnt, 1);

        // both error pulses in one cycle, frame discarded
        clr();
        tick(P0, S1);
        tick(P1, S2);
        tick(P0, SX);
        chk("both_err_frame", err_frame, 1);
        chk("both_err_seg", err_seg, 1);
        tick(P1, S2);
        tick(P2, S3);
        tick(P3, SB);
        idle(4);
        chk("both_no_valido", vcnt, 0);
        chk("both_valor_kept", valor, 46);

        // reset during accumulation
        clr();
        frame(S1, S1, S1, S1);
        idle(2);
        #2 reset = 1'b0;
        #1;
        chk("midrst_valor", valor, 0);
        chk("midrst_valido", valido, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_err_frame", err_frame, 0);
        chk("midrst_err_seg", err_seg, 0);
        @(posedge clk_d);
        @(posedge clk_d);
        #1 reset = 1'b1;
        clr();
        idle(6);
        chk("midrst_no_valido", vcnt, 0);
        chk("midrst_valor_after", valor, 0);

        // 125, 125, 150
        clr();
        frame(S5, S2, S1, SB);
        frame(S5, S2, S1, SB);
        frame(S0, S5, S1, SB);
        idle(4);
`ifdef SEG7_RB_STABLE_EN
        chk("stable_count", vcnt, 1);
        chk("stable_valor", valor, 125);
`else
        chk("seq_count", vcnt, 3);
        chk("seq_valor", valor, 150);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
